// File: rtl/fifo_sched.sv
// Purpose : round-robin scheduler sharing one byte FIFO between two producers and one consumer.
// Latency : eligible in IDLE at cycle n -> one-cycle strobe/ack at n+1 -> GAP_CYCLES low -> IDLE at n+2+GAP_CYCLES.
// Backpres: producers hold wrN_req until wrN_ack; pops wait until the single-entry rd_valid/rd_data register is free.
//
// Ports:
//   clk, reset (async, active-low)
//   wr0_req/wr0_data/wr0_ack, wr1_req/wr1_data/wr1_ack : producer request/ack handshakes
//   rd_valid/rd_ready/rd_data                           : consumer valid-ready output register
//   fifo_push/fifo_pop/fifo_din                         : registered strobes and data to the FIFO
//   fifo_dout/fifo_full/fifo_empty                      : FIFO data and flags
`timescale 1ns/1ps
module fifo_sched #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr0_req,
  input  logic [7:0] wr0_data,
  output logic       wr0_ack,
  input  logic       wr1_req,
  input  logic [7:0] wr1_data,
  output logic       wr1_ack,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       fifo_push,
  output logic       fifo_pop,
  output logic [7:0] fifo_din,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_full,
  input  logic       fifo_empty
);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [1:0] rr_q;
  logic [1:0] rr_d;
  logic [1:0] gnt_q;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [3:0] elig;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [3:0] gap_cnt_q;
  logic       push_q;
  logic       pop_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       rd_valid_q;
  logic [7:0] din_q;
  logic [7:0] rd_data_q;

  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Requester 2 is the read side; bit 3 is padding so a 2-bit index never
  // selects outside the vector.
  always_comb begin
    elig    = {1'b0, ~rd_valid_q & ~fifo_empty, wr1_req & ~fifo_full, wr0_req & ~fifo_full};
    cand1   = rr_next(rr_q);
    cand2   = rr_next(cand1);
    gnt_vld = 1'b1;
    gnt_idx = rr_q;
    if (elig[rr_q]) begin
      gnt_idx = rr_q;
    end else if (elig[cand1]) begin
      gnt_idx = cand1;
    end else if (elig[cand2]) begin
      gnt_idx = cand2;
    end else begin
      gnt_vld = 1'b0;
    end
    rr_d = gnt_vld ? rr_next(gnt_idx) : rr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      gnt_q      <= 2'd0;
      gap_cnt_q  <= 4'd0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      din_q      <= 8'h00;
      rd_data_q  <= 8'h00;
    end else begin
      // Consumer handshake; a new pop can only be granted once this clears,
      // so the set below never collides with a pending byte.
      if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          rr_q <= rr_d;
          if (gnt_vld) begin
            state_q <= STROBE;
            gnt_q   <= gnt_idx;
            case (gnt_idx)
              2'd0: begin
                din_q  <= wr0_data;
                push_q <= 1'b1;
                ack0_q <= 1'b1;
              end
              2'd1: begin
                din_q  <= wr1_data;
                push_q <= 1'b1;
                ack1_q <= 1'b1;
              end
              default: begin
                pop_q <= 1'b1;
              end
            endcase
          end
        end
        STROBE: begin
          push_q    <= 1'b0;
          pop_q     <= 1'b0;
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          gap_cnt_q <= 4'd0;
          state_q   <= GAP;
        end
        GAP: begin
          // The FIFO has presented the popped byte by the end of the gap.
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= IDLE;
            gap_cnt_q <= 4'd0;
            if (gnt_q == 2'd2) begin
              rd_data_q  <= fifo_dout;
              rd_valid_q <= 1'b1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr0_ack   = ack0_q;
  assign wr1_ack   = ack1_q;
  assign fifo_push = push_q;
  assign fifo_pop  = pop_q;
  assign fifo_din  = din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_fifo_sched.sv
// Purpose : directed + random bench for fifo_sched with a byte-FIFO model and data scoreboards.
// Latency : checks strobe/ack timing, pop-to-data latency and round-robin spacing.
// Backpres: consumer rd_ready driven directly; FIFO flags from the model, optionally forced.
`timescale 1ns/1ps
module tb_fifo_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr0_req, wr1_req, rd_ready;
  logic [7:0] wr0_data, wr1_data;
  logic       force_full, force_empty;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       sb_en;

  wire        wr0_ack, wr1_ack, rd_valid, fifo_push, fifo_pop;
  wire  [7:0] rd_data, fifo_din;
  wire        wr0_ack3, wr1_ack3, rd_valid3, fifo_push3, fifo_pop3;
  wire  [7:0] rd_data3, fifo_din3;

  int checks = 0;
  int fails  = 0;
  int cyc_cnt = 0;
  int psh_cnt = 0;
  int ack0_cnt = 0;

  logic [7:0] wr_exp_q[$];
  logic [7:0] rd_exp_q[$];

  // FIFO model: a pop edge registers the head onto fifo_dout.
  logic [7:0] mem[$];
  int         m_cnt = 0;
  logic [7:0] dout_m = 8'h00;

  assign fifo_full  = force_full  | (m_cnt >= 16);
  assign fifo_empty = force_empty | (m_cnt == 0);
  assign fifo_dout  = dout_m;

  always #5 clk = ~clk;

  fifo_sched #(.GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  fifo_sched #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .wr0_req(wr0_req), .wr0_data(wr0_data), .wr0_ack(wr0_ack3),
    .wr1_req(wr1_req), .wr1_data(wr1_data), .wr1_ack(wr1_ack3),
    .rd_valid(rd_valid3), .rd_ready(rd_ready), .rd_data(rd_data3),
    .fifo_push(fifo_push3), .fifo_pop(fifo_pop3), .fifo_din(fifo_din3),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 wr0_ack, 1 wr1_ack, 2 fifo_pop, 3 rd_valid, other any ack
  task automatic wait_sig(input int which, input int max_cyc, output logic ok, output int at_cyc);
    logic hit;
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = wr0_ack;
        1:       hit = wr1_ack;
        2:       hit = fifo_pop;
        3:       hit = rd_valid;
        default: hit = wr0_ack | wr1_ack;
      endcase
      if (hit === 1'b1) begin
        ok = 1'b1;
        at_cyc = cyc_cnt;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt = cyc_cnt + 1;
  end

  initial forever begin
    @(posedge clk or negedge reset);
    if (reset !== 1'b1) begin
      mem.delete();
      m_cnt  <= 0;
      dout_m <= 8'h00;
    end else begin
      if (fifo_push === 1'b1) mem.push_back(fifo_din);
      if (fifo_pop === 1'b1 && mem.size() > 0) dout_m <= mem.pop_front();
      m_cnt <= mem.size();
    end
  end

  // Per-cycle invariants for both instances plus data scoreboards for dut.
  initial begin
    int   hi_run[2];
    int   lo_run[2];
    int   gap_p[2];
    logic s[2];
    gap_p = '{1, 3};
    hi_run = '{0, 0};
    lo_run = '{100, 100};
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        hi_run = '{0, 0};
        lo_run = '{100, 100};
      end else begin
        check("push_pop_excl",  {31'd0, fifo_push & fifo_pop}, 0);
        check("ack_excl",       {31'd0, wr0_ack & wr1_ack}, 0);
        check("ack_with_push",  {31'd0, wr0_ack | wr1_ack}, {31'd0, fifo_push});
        check("push_pop_excl3", {31'd0, fifo_push3 & fifo_pop3}, 0);
        check("ack_excl3",      {31'd0, wr0_ack3 & wr1_ack3}, 0);
        s[0] = fifo_push | fifo_pop;
        s[1] = fifo_push3 | fifo_pop3;
        for (int i = 0; i < 2; i++) begin
          if (s[i]) begin
            if (lo_run[i] > 0) check($sformatf("gap_low_%0d", i), {31'd0, lo_run[i] >= gap_p[i]}, 1);
            hi_run[i]++;
            lo_run[i] = 0;
          end else begin
            if (hi_run[i] > 0) check($sformatf("strobe_width_%0d", i), hi_run[i], 1);
            hi_run[i] = 0;
            lo_run[i]++;
          end
        end
        if (fifo_push === 1'b1) psh_cnt++;
        if (wr0_ack === 1'b1) ack0_cnt++;
        if (sb_en && fifo_push === 1'b1) begin
          check("sb_wr_avail", {31'd0, wr_exp_q.size() > 0}, 1);
          if (wr_exp_q.size() > 0) check("sb_wr_data", fifo_din, wr_exp_q.pop_front());
        end
        if (sb_en && rd_valid === 1'b1 && rd_ready === 1'b1) begin
          check("sb_rd_avail", {31'd0, rd_exp_q.size() > 0}, 1);
          if (rd_exp_q.size() > 0) check("sb_rd_data", rd_data, rd_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic ok;
    int   at, last, who, n, na, t_pop, t_rdv;
    logic seen;
    reset = 1'b1;
    wr0_req = 1'b0; wr1_req = 1'b0; rd_ready = 1'b0;
    wr0_data = 8'h00; wr1_data = 8'h00;
    force_full = 1'b0; force_empty = 1'b1; sb_en = 1'b1;
    #2 reset = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_push",    {31'd0, fifo_push}, 0);
    check("rst_pop",     {31'd0, fifo_pop}, 0);
    check("rst_ack0",    {31'd0, wr0_ack}, 0);
    check("rst_ack1",    {31'd0, wr1_ack}, 0);
    check("rst_rdvalid", {31'd0, rd_valid}, 0);
    check("rst_din",     fifo_din, 8'h00);
    check("rst_rddata",  rd_data, 8'h00);
    @(posedge clk); #1 reset = 1'b1;

    // Single push
    @(posedge clk); #1 wr0_req = 1'b1; wr0_data = 8'hA5; wr_exp_q.push_back(8'hA5);
    @(negedge clk);
    check("t1_no_early_push", {31'd0, fifo_push}, 0);
    @(negedge clk);
    check("t1_push",  {31'd0, fifo_push}, 1);
    check("t1_ack0",  {31'd0, wr0_ack}, 1);
    check("t1_din",   fifo_din, 8'hA5);
    @(posedge clk); #1 wr0_req = 1'b0;
    n = psh_cnt;
    @(negedge clk);
    check("t1_push_1cyc", {31'd0, fifo_push}, 0);
    check("t1_ack_1cyc",  {31'd0, wr0_ack}, 0);
    repeat (6) @(posedge clk);
    #1 check("t1_no_more_push", psh_cnt, n);

    // Round-robin between the two producers
    do_reset();
    wr_exp_q.push_back(8'h10); wr_exp_q.push_back(8'h20);
    wr_exp_q.push_back(8'h11); wr_exp_q.push_back(8'h21);
    @(posedge clk); #1 wr0_req = 1'b1; wr0_data = 8'h10; wr1_req = 1'b1; wr1_data = 8'h20;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_sig(4, 20, ok, at);
      check("rr_timeout", {31'd0, ok}, 1);
      who = (wr1_ack === 1'b1) ? 1 : 0;
      check("rr_order", who, i % 2);
      if (i > 0) check("rr_spacing", at - last, 3);
      last = at;
      if (who == 0) wr0_data = 8'h11; else wr1_data = 8'h21;
    end
    wr0_req = 1'b0; wr1_req = 1'b0;

    // Push then pop through the single-entry read register
    do_reset();
    force_empty = 1'b0; rd_ready = 1'b0;
    @(posedge clk); #1 wr1_req = 1'b1; wr1_data = 8'h3C;
    wr_exp_q.push_back(8'h3C); rd_exp_q.push_back(8'h3C);
    wait_sig(1, 20, ok, at);
    check("pp_ack1_timeout", {31'd0, ok}, 1);
    @(posedge clk); #1 wr1_req = 1'b0;
    wait_sig(2, 20, ok, t_pop);
    check("pp_pop_timeout", {31'd0, ok}, 1);
    wait_sig(3, 20, ok, t_rdv);
    check("pp_rdvalid_timeout", {31'd0, ok}, 1);
    check("pp_pop_to_valid", t_rdv - t_pop, 2);
    check("pp_rddata", rd_data, 8'h3C);
    repeat (3) @(negedge clk);
    check("pp_rdvalid_hold", {31'd0, rd_valid}, 1);
    check("pp_rddata_hold",  rd_data, 8'h3C);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(negedge clk);
    check("pp_rdvalid_clear", {31'd0, rd_valid}, 0);
    check("pp_rddata_kept",   rd_data, 8'h3C);

    // Full stall
    do_reset();
    force_full = 1'b1; force_empty = 1'b1;
    @(posedge clk); #1 wr0_req = 1'b1; wr0_data = 8'h5A;
    n = psh_cnt; na = ack0_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("full_no_push", psh_cnt, n);
    check("full_no_ack",  ack0_cnt, na);
    wr_exp_q.push_back(8'h5A);
    force_full = 1'b0;
    @(negedge clk);
    check("full_drop_idle", {31'd0, fifo_push}, 0);
    @(negedge clk);
    check("full_drop_push", {31'd0, fifo_push}, 1);
    check("full_drop_ack",  {31'd0, wr0_ack}, 1);
    @(posedge clk); #1 wr0_req = 1'b0;

    // Reset during the strobe cycle of a pop
    do_reset();
    force_empty = 1'b1; rd_ready = 1'b0;
    @(posedge clk); #1 wr0_req = 1'b1; wr0_data = 8'h77; wr_exp_q.push_back(8'h77);
    wait_sig(0, 20, ok, at);
    check("rm_ack0_timeout", {31'd0, ok}, 1);
    @(posedge clk); #1 wr0_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 force_empty = 1'b0;
    wait_sig(2, 20, ok, at);
    check("rm_pop_timeout", {31'd0, ok}, 1);
    reset = 1'b0;
    #1;
    check("rm_pop_drop", {31'd0, fifo_pop}, 0);
    check("rm_push_low", {31'd0, fifo_push}, 0);
    @(posedge clk); #1 reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rd_valid;
    end
    check("rm_rdvalid_stays_low", {31'd0, seen}, 0);
    check("rm_rr_zero", {30'd0, dut.rr_q}, 0);
    check("sb_wr_drained", wr_exp_q.size(), 0);
    check("sb_rd_drained", rd_exp_q.size(), 0);

    // Random soak on both GAP settings; invariants checked by the monitor
    sb_en = 1'b0;
    repeat (2000) begin
      @(posedge clk); #1;
      wr0_req     = 1'($urandom_range(0, 1));
      wr1_req     = 1'($urandom_range(0, 1));
      wr0_data    = 8'($urandom_range(0, 255));
      wr1_data    = 8'($urandom_range(0, 255));
      rd_ready    = 1'($urandom_range(0, 1));
      force_full  = ($urandom_range(0, 3) == 0);
      force_empty = ($urandom_range(0, 3) == 0);
    end
    wr0_req = 1'b0; wr1_req = 1'b0;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
